// File: rtl/note_sequencer.sv
// note_sequencer: steps through a song held in an external combinational note ROM.
// Each ROM word is {key[3:0], dur[2:0]}. The word is latched and held for dur quarter-beats,
// where one quarter-beat is QUARTER_TICKS clock cycles. A duration of 0 is treated as 1.
// The block emits a one-cycle note_valid pulse at the onset of every non-rest note.
// It emits a one-cycle beat_tick in the first cycle of each new quarter-beat.
// It also supports start/restart, pause/resume and end-of-song.
module note_sequencer #(
    parameter int QUARTER_TICKS = 25_000_000,
    parameter int SONG_LEN      = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] rom_addr,
    input  logic [6:0] rom_notes,
    output logic [3:0] note_key,
    output logic [2:0] note_dur,
    output logic       note_valid,
    output logic       beat_tick,
    output logic       playing,
    output logic       done
);

    localparam int             QCW       = (QUARTER_TICKS > 2) ? $clog2(QUARTER_TICKS) : 1;
    localparam logic [QCW-1:0] QC_LAST   = QCW'(QUARTER_TICKS - 1);
    localparam logic [7:0]     ADDR_LAST = 8'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // A zero duration in the ROM still has to take up time, so it plays as one quarter.
    function automatic logic [2:0] fix_dur(input logic [2:0] raw);
        if (raw == 3'd0) begin
            fix_dur = 3'd1;
        end else begin
            fix_dur = raw;
        end
    endfunction

    state_t         state_q, state_d;
    logic [7:0]     rom_addr_q, rom_addr_d;
    logic [3:0]     note_key_q, note_key_d;
    logic [2:0]     note_dur_q, note_dur_d;
    logic [2:0]     quarters_left_q, quarters_left_d;
    logic [QCW-1:0] quarter_cnt_q, quarter_cnt_d;
    logic           note_valid_q, note_valid_d;
    logic           beat_tick_q, beat_tick_d;
    logic           playing_q, playing_d;
    logic           done_q, done_d;

    // Next-state, counter and output computation for the sequencer FSM.
    always_comb begin
        state_d         = state_q;
        rom_addr_d      = rom_addr_q;
        note_key_d      = note_key_q;
        note_dur_d      = note_dur_q;
        quarters_left_d = quarters_left_q;
        quarter_cnt_d   = quarter_cnt_q;
        note_valid_d    = 1'b0;
        beat_tick_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    rom_addr_d = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_FETCH: begin
                if (start) begin
                    state_d         = S_FETCH;
                    rom_addr_d      = 8'd0;
                    quarters_left_d = 3'd0;
                    quarter_cnt_d   = '0;
                end else begin
                    // pause is ignored here; it takes effect on the first PLAY cycle
                    state_d         = S_PLAY;
                    note_key_d      = rom_notes[6:3];
                    note_dur_d      = fix_dur(rom_notes[2:0]);
                    quarters_left_d = fix_dur(rom_notes[2:0]);
                    quarter_cnt_d   = '0;
                    note_valid_d    = (rom_notes[6:3] != 4'd0);
                end
            end

            // The cycle that releases a pause counts, so a pause held for N cycles
            // stretches the note by exactly N cycles.
            S_PLAY, S_PAUSED: begin
                if (start) begin
                    state_d         = S_FETCH;
                    rom_addr_d      = 8'd0;
                    quarters_left_d = 3'd0;
                    quarter_cnt_d   = '0;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end else if (quarter_cnt_q == QC_LAST) begin
                    quarter_cnt_d   = '0;
                    beat_tick_d     = 1'b1;
                    quarters_left_d = quarters_left_q - 3'd1;
                    if (quarters_left_q == 3'd1) begin
                        if (rom_addr_q == ADDR_LAST) begin
                            state_d    = S_DONE;
                            note_key_d = 4'd0;
                        end else begin
                            state_d    = S_FETCH;
                            rom_addr_d = rom_addr_q + 8'd1;
                        end
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    state_d       = S_PLAY;
                    quarter_cnt_d = quarter_cnt_q + QCW'(1);
                end
            end

            S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    rom_addr_d = 8'd0;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d         = S_IDLE;
                rom_addr_d      = 8'd0;
                note_key_d      = 4'd0;
                note_dur_d      = 3'd0;
                quarters_left_d = 3'd0;
                quarter_cnt_d   = '0;
            end
        endcase

        playing_d = (state_d == S_FETCH) || (state_d == S_PLAY) || (state_d == S_PAUSED);
        done_d    = (state_d == S_DONE);
    end

    // State, counters and registered outputs, with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rom_addr_q      <= 8'd0;
            note_key_q      <= 4'd0;
            note_dur_q      <= 3'd0;
            quarters_left_q <= 3'd0;
            quarter_cnt_q   <= '0;
            note_valid_q    <= 1'b0;
            beat_tick_q     <= 1'b0;
            playing_q       <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rom_addr_q      <= rom_addr_d;
            note_key_q      <= note_key_d;
            note_dur_q      <= note_dur_d;
            quarters_left_q <= quarters_left_d;
            quarter_cnt_q   <= quarter_cnt_d;
            note_valid_q    <= note_valid_d;
            beat_tick_q     <= beat_tick_d;
            playing_q       <= playing_d;
            done_q          <= done_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign note_key   = note_key_q;
    assign note_dur   = note_dur_q;
    assign note_valid = note_valid_q;
    assign beat_tick  = beat_tick_q;
    assign playing    = playing_q;
    assign done       = done_q;

endmodule
